// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
//   Button/LED panel sequencer. Each raw push-button is synchronized and
//   debounced. Debounced rising edges become commands for a four-mode
//   pattern machine. The LED drive follows that machine, stepped by an
//   internal tick.
//
// Parameters
//   DEBOUNCE_CYCLES : stable synchronized cycles needed to accept a new level (>=2)
//   TICK_CYCLES     : clock cycles per pattern step (>=2)
//
// Ports
//   clk    : single clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   btn    : raw asynchronous buttons, active-high
//            [0] next mode, [1] pause toggle, [2] direction toggle, [3] restart
//   led    : registered LED drive, active-high
//   mode   : 0 STATIC, 1 BLINK, 2 CHASE, 3 COUNT
//   paused : registered pause flag
module led_pattern_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       paused
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        M_STATIC = 2'd0,
        M_BLINK  = 2'd1,
        M_CHASE  = 2'd2,
        M_COUNT  = 2'd3
    } mode_e;

    // ------------------------------------------------------------------
    // Input path: 2-FF synchronizer, per-button debouncer, edge detect
    // ------------------------------------------------------------------
    logic [3:0]    sync1, sync2;
    logic [3:0]    btn_db, btn_db_q;
    logic [CW-1:0] db_cnt [4];
    logic [3:0]    press;

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            btn_db   <= '0;
            btn_db_q <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it
            // can and must be cleared by the async reset like any other state.
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            btn_db_q <= btn_db;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    btn_db[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Rising edges only; releases carry no command.
    assign press = btn_db & ~btn_db_q;

    // ------------------------------------------------------------------
    // Mode / pattern state machine
    // ------------------------------------------------------------------
    mode_e         mode_q, mode_d;
    logic          paused_q, paused_d;
    logic          dir_q, dir_d;
    logic [3:0]    led_q, led_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          restart;
    logic          tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= M_STATIC;
            paused_q   <= 1'b0;
            dir_q      <= 1'b0;
            led_q      <= '0;
            tick_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            paused_q   <= paused_d;
            dir_q      <= dir_d;
            led_q      <= led_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign tick = (tick_cnt_q == TICK_MAX) && !paused_q;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        mode_d     = mode_q;
        paused_d   = paused_q;
        dir_d      = dir_q;
        restart    = 1'b0;
        led_d      = led_q;
        tick_cnt_d = tick_cnt_q;

        // Mode advance wins over pause and restart in the same cycle.
        if (press[0]) begin
            case (mode_q)
                M_STATIC: mode_d = M_BLINK;
                M_BLINK:  mode_d = M_CHASE;
                M_CHASE:  mode_d = M_COUNT;
                default:  mode_d = M_STATIC;
            endcase
            paused_d = 1'b0;
            restart  = 1'b1;
        end else begin
            if (press[1]) paused_d = ~paused_q;
            if (press[3]) restart  = 1'b1;
        end
        if (press[2]) dir_d = ~dir_q;

        // Tick counter freezes while paused and resumes from where it stopped.
        if (restart)        tick_cnt_d = '0;
        else if (tick)      tick_cnt_d = '0;
        else if (!paused_q) tick_cnt_d = tick_cnt_q + TW'(1);

        if (restart) begin
            // Entry pattern of the mode being entered, in the direction
            // that will be in force after this edge.
            case (mode_d)
                M_STATIC: led_d = btn_db;
                M_BLINK:  led_d = 4'b1111;
                M_CHASE:  led_d = dir_d ? 4'b1000 : 4'b0001;
                default:  led_d = 4'b0000;
            endcase
        end else begin
            case (mode_q)
                M_STATIC: led_d = btn_db;
                M_BLINK:  if (tick) led_d = ~led_q;
                M_CHASE:  if (tick) led_d = dir_q ? {led_q[0], led_q[3:1]}
                                                  : {led_q[2:0], led_q[3]};
                default:  if (tick) led_d = dir_q ? led_q - 4'd1 : led_q + 4'd1;
            endcase
        end
    end

    assign led    = led_q;
    assign mode   = mode_q;
    assign paused = paused_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with DEBOUNCE_CYCLES=16, TICK_CYCLES=8.
// Outputs are sampled 1 time unit after the rising edge. Every expected value
// below is derived by hand from the edge counts noted next to each step.
module tb_led_pattern_ctrl;

    localparam int D = 16;
    localparam int T = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] led;
    logic [1:0] mode;
    logic       paused;

    int checks   = 0;
    int failures = 0;

    led_pattern_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .TICK_CYCLES    (T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .led   (led),
        .mode  (mode),
        .paused(paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the mask until the edge where btn_db picks it up (edge e+D+2),
    // then release; the command takes effect on the following edge.
    task automatic push_arm(input logic [3:0] mask);
        btn = mask;
        cyc(D + 2);
        btn = 4'b0000;
    endtask

    // Full press: returns just after the command edge (e+D+3).
    task automatic push(input logic [3:0] mask);
        push_arm(mask);
        cyc(1);
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 4'b0000;

        // Reset state
        cyc(3);
        check("rst_led",    led,           4'b0000);
        check("rst_mode",   {2'b00, mode}, 4'd0);
        check("rst_paused", {3'b000, paused}, 4'd0);
        rst_n = 1'b1;
        cyc(2);

        // Glitch of D-2 cycles: no debounced change, no event
        btn = 4'b0001;
        cyc(D - 2);
        btn = 4'b0000;
        cyc(D + 6);
        check("glitch_mode", {2'b00, mode}, 4'd0);
        check("glitch_led",  led,           4'b0000);

        // Clean press held D+4 cycles: mode changes exactly at edge e+D+3
        btn = 4'b0001;
        cyc(D + 2);
        check("press_early_mode", {2'b00, mode}, 4'd0);
        cyc(1);
        check("blink_mode",  {2'b00, mode}, 4'd1);
        check("blink_entry", led,           4'b1111);
        cyc(1);
        btn = 4'b0000;
        cyc(T - 2);
        check("blink_hold", led, 4'b1111);
        cyc(1);
        check("blink_step", led, 4'b0000);
        cyc(12);

        // CHASE, dir=0: rotate left every T edges
        push(4'b0001);
        check("chase_mode",  {2'b00, mode}, 4'd2);
        check("chase_entry", led,           4'b0001);
        cyc(T - 1);
        check("chase_hold", led, 4'b0001);
        cyc(1);
        check("chase_s1", led, 4'b0010);
        cyc(T);
        check("chase_s2", led, 4'b0100);
        cyc(T);
        check("chase_s3", led, 4'b1000);
        cyc(T);
        check("chase_wrap", led, 4'b0001);

        // COUNT up, then flip direction, pause, resume
        push(4'b0001);                         // restart edge r
        check("count_mode",  {2'b00, mode}, 4'd3);
        check("count_entry", led,           4'b0000);
        cyc(T - 1);
        check("count_hold", led, 4'b0000);
        cyc(1);
        check("count_up1", led, 4'b0001);      // r+8
        push(4'b0100);                         // dir flips at r+27
        check("count_up3", led, 4'b0011);
        cyc(5);
        check("count_dn1", led, 4'b0010);      // r+32
        cyc(T);
        check("count_dn2", led, 4'b0001);
        cyc(T);
        check("count_dn3", led, 4'b0000);
        cyc(T);
        check("count_dnwrap", led, 4'b1111);   // r+56
        push(4'b0010);                         // pause at r+75
        check("pause_flag", {3'b000, paused}, 4'd1);
        check("pause_led",  led,              4'b1101);
        cyc(5 * T);
        check("frozen_led",  led,              4'b1101);
        check("frozen_flag", {3'b000, paused}, 4'd1);
        push(4'b0010);                         // resume at r+134, counter held at 3
        check("resume_flag", {3'b000, paused}, 4'd0);
        check("resume_led",  led,              4'b1101);
        cyc(4);
        check("resume_hold", led, 4'b1101);
        cyc(1);
        check("resume_step", led, 4'b1100);    // r+139
        cyc(30);
        check("count_1001", led, 4'b1001);     // r+169

        // Restart + pause toggle together while at 0110
        push_arm(4'b1010);
        check("pre_restart_led",    led,              4'b0110);
        check("pre_restart_paused", {3'b000, paused}, 4'd0);
        cyc(1);
        check("restart_led",    led,              4'b0000);
        check("restart_paused", {3'b000, paused}, 4'd1);
        check("restart_mode",   {2'b00, mode},    4'd3);
        cyc(17);
        check("restart_frozen", led, 4'b0000);

        // Mode advance + pause toggle together while paused: advance wins
        push(4'b0011);
        check("adv_mode",   {2'b00, mode},    4'd0);
        check("adv_paused", {3'b000, paused}, 4'd0);
        check("adv_led",    led,              4'b0011);
        cyc(17);
        check("static_hold", led, 4'b0011);
        cyc(1);
        check("static_follow", led, 4'b0000);

        // Into CHASE (dir=1 now) and pause, then async reset mid-cycle
        push(4'b0001);
        check("mode_to_blink", {2'b00, mode}, 4'd1);
        cyc(17);
        push(4'b0001);
        check("chase2_mode",  {2'b00, mode}, 4'd2);
        check("chase2_entry", led,           4'b1000);
        cyc(10);
        check("chase2_right", led, 4'b0100);
        cyc(7);
        push(4'b0010);
        check("chase2_paused", {3'b000, paused}, 4'd1);
        check("chase2_wrap",   led,              4'b1000);
        #4;
        rst_n = 1'b0;
        #1;
        check("async_rst_led",    led,              4'b0000);
        check("async_rst_mode",   {2'b00, mode},    4'd0);
        check("async_rst_paused", {3'b000, paused}, 4'd0);
        @(posedge clk);
        #1;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // STATIC after reset: led follows btn_db one edge later
        btn = 4'b0100;
        cyc(D + 2);
        check("static_early", led, 4'b0000);
        cyc(1);
        check("static_led",  led,           4'b0100);
        check("static_mode", {2'b00, mode}, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Sequencer for the board's 4-button / 4-LED panel. It synchronizes and debounces the raw push-buttons and turns button presses into commands for a small mode state machine. It drives the four LEDs with a static, blinking, chasing or counting pattern paced by an internal tick. It sits between the board button pins and the LED pins and replaces direct combinational button-to-LED wiring.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a debounced button level changes; ≥2. Hardware builds override it, e.g. 1_000_000.
- `TICK_CYCLES`, default 8: clock cycles per pattern step; ≥2.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn` in 4: raw asynchronous push-buttons, active-high.
- `led` out 4: registered LED drive, active-high.
- `mode` out 2: current mode; 0 STATIC, 1 BLINK, 2 CHASE, 3 COUNT.
- `paused` out 1: registered pause flag.

## Operation
- **Input path, per button:** 2-FF synchronizer, then debouncer.
  - Debouncer: counter increments while the synchronized value ≠ `btn_db`. It clears on any cycle where they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES` − 1 while still mismatched, `btn_db` takes the new value and the counter clears.
- **Press event:** `press[i] = btn_db[i] & ~btn_db_q[i]`, a one-cycle pulse on the debounced rising edge. Releases generate no event.
- **Commands**, all evaluated on the same edge:
  - `press[0]`: advance mode STATIC→BLINK→CHASE→COUNT→STATIC. Clears `paused`, restarts the pattern. Overrides `press[1]` and `press[3]` in that cycle.
  - `press[1]`: toggle `paused`.
  - `press[2]`: toggle direction `dir` (0 = up/left, 1 = down/right). Always honored, including alongside `press[0]`.
  - `press[3]`: restart the pattern in the current mode. `paused` is unchanged, unless `press[1]` in the same cycle toggles it.
- **Restart:** tick counter ← 0; `led` ← the mode's entry pattern on that edge.
- **Tick:**
  - Counter runs 0..`TICK_CYCLES`−1 and wraps.
  - `tick` asserts on the cycle the counter equals `TICK_CYCLES`−1 and `paused`=0.
  - The counter holds while `paused`=1 and is ignored in STATIC.
- **Patterns**, updated on the edge where `tick`=1:
  - STATIC: `led` ← `btn_db` every cycle; tick, pause and dir have no effect on `led`. Entry value is the current `btn_db`.
  - BLINK: entry 1111; each tick `led` ← ~`led`; `dir` ignored.
  - CHASE: entry 0001 if `dir`=0, else 1000. Each tick rotates left (0001→0010→0100→1000→0001) if `dir`=0, right if `dir`=1.
  - COUNT: entry 0000. Each tick ±1 modulo 16: 1111→0000 up, 0000→1111 down.
- A direction change takes effect on the next tick; it does not restart the pattern.

## Timing
- **Reset values**, applied asynchronously and immediately, including mid-pattern or mid-debounce:
  - Outputs: `led`=0000, `mode`=0, `paused`=0.
  - Internal state: `dir`=0, `btn_db`=0000, all counters 0.
- **Input latency:**
  - A raw `btn` change held stable, first sampled at edge k, updates `btn_db` at edge k+1+`DEBOUNCE_CYCLES`.
  - `press` is high during the following cycle.
  - `mode`/`paused`/`led` update at edge k+2+`DEBOUNCE_CYCLES`.
- **STATIC mode:** `led` follows `btn_db` with 1 cycle latency.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no `btn_db` change and no event.
- **Step timing:**
  - After restart, the first tick-driven step occurs `TICK_CYCLES` edges later.
  - Subsequent steps occur every `TICK_CYCLES` edges.
- **Pause and resume:** on resume, the tick counter continues from its held value. It does not restart.
- **Independent buttons:** multiple buttons debounce independently, so simultaneous raw presses may produce events on different cycles.

## Test plan
- **Reset:** assert `rst_n`=0 mid-CHASE, async, between clock edges → `led`=0000, `mode`=0, `paused`=0 before the next edge. Release, drive `btn`=0101 → `led`=0101 at edge `DEBOUNCE_CYCLES`+2 after the first sampling edge.
- **Debounce:** pulse `btn[0]` high for `DEBOUNCE_CYCLES`−2 cycles → `mode` stays 0. Hold it for `DEBOUNCE_CYCLES`+4 cycles → `mode`=1 and `led`=1111 at the exact latency. Then `led`=0000 `TICK_CYCLES` edges later.
- **Mode wrap:** four clean `btn[0]` presses → `mode` sequence 1,2,3,0. In CHASE, `led` steps 0001,0010,0100,1000,0001 every `TICK_CYCLES` edges.
- **COUNT with direction and pause:**
  - Up from 0000 for 3 ticks gives 0011.
  - Press `btn[2]` → next steps 0010, 0001, 0000, 1111 (down-wrap).
  - Press `btn[1]` → `paused`=1 and `led` frozen for 5×`TICK_CYCLES`.
  - Press `btn[1]` again → stepping resumes, with the first step ≤`TICK_CYCLES` edges later.
- **Simultaneous events:** `press[0]` and `press[1]` on the same cycle while `paused`=1 → mode advances, `paused`=0. `press[3]` and `press[1]` on the same cycle in COUNT at 0110 → `led`=0000 and `paused` toggled.
